// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand select, ALU, branch
// target, destination select, HI/LO with an iterative unsigned multiply/divide
// unit, and the EX/MEM pipeline register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no multicycle op running; a MULTU/DIVU in EX starts one
// BUSY  | one multiply/divide step per cycle, front end stalled
// DONE  | HI/LO written; the MULTU/DIVU leaves EX this cycle
module execute_stage #(
  parameter int len = 32,
  parameter int NB  = $clog2(len)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [len-1:0]  in_pc_next,
  input  logic [len-1:0]  in_read_data_1,
  input  logic [len-1:0]  in_read_data_2,
  input  logic [len-1:0]  in_sign_extend,
  input  logic [4:0]      in_shamt,
  input  logic [NB-1:0]   in_rt,
  input  logic [NB-1:0]   in_rd,
  input  logic [5:0]      in_execute_bus,
  input  logic [2:0]      in_memory_bus,
  input  logic [1:0]      in_writeBack_bus,
  input  logic            flush,
  output logic            stall,
  output logic [len-1:0]  out_addr_mem,
  output logic [len-1:0]  out_write_data,
  output logic [2:0]      out_memory_bus,
  output logic [1:0]      out_writeBack_bus,
  output logic [NB-1:0]   out_write_reg,
  output logic            out_zero_flag,
  output logic [len-1:0]  out_pc_branch
);

  localparam int CW = $clog2(len);
  localparam logic [CW-1:0] LAST = CW'(len - 1);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MULT = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_MFHI = 4'd14;
  localparam logic [3:0] ALU_MFLO = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            md_div;
  logic [len-1:0]  operand;
  logic [len-1:0]  acc_hi;
  logic [len-1:0]  acc_lo;
  logic [len-1:0]  hi_reg;
  logic [len-1:0]  lo_reg;

  logic            reg_dst;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic [len-1:0]  op_a;
  logic [len-1:0]  op_b;
  logic            is_md;
  logic [len-1:0]  alu_res;
  logic [NB-1:0]   write_reg;
  logic [len-1:0]  pc_branch;

  logic [len:0]    mul_sum;
  logic [len:0]    div_shift;
  logic [len:0]    div_diff;
  logic            div_ok;
  logic [len-1:0]  step_hi;
  logic [len-1:0]  step_lo;

  assign reg_dst   = in_execute_bus[0];
  assign alu_src   = in_execute_bus[1];
  assign alu_op    = in_execute_bus[5:2];
  assign op_a      = in_read_data_1;
  assign op_b      = alu_src ? in_sign_extend : in_read_data_2;
  assign is_md     = (alu_op == ALU_MULT) || (alu_op == ALU_DIVU);
  assign write_reg = reg_dst ? in_rd : in_rt;
  assign pc_branch = in_pc_next + (in_sign_extend << 2);

  // A flush kills the instruction in EX, so it also releases any stall at once.
  assign stall = !flush && (((state == IDLE) && is_md) || (state == BUSY));

  // ALU result selection; MULTU/DIVU leave a zero result in the pipeline.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(len-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(len-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_res = op_b << in_shamt;
      ALU_SRL:  alu_res = op_b >> in_shamt;
      ALU_SRA:  alu_res = $signed(op_b) >>> in_shamt;
      ALU_LUI:  alu_res = op_b << 16;
      ALU_MFHI: alu_res = hi_reg;
      ALU_MFLO: alu_res = lo_reg;
      default:  alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // Multiply: {acc_hi,acc_lo} starts as {0, multiplier}, operand = multiplicand.
  // Divide: acc_hi is the remainder, acc_lo shifts the dividend out and the
  // quotient in. A zero divisor always "fits", giving all-ones and HI = A.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi, acc_lo[len-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ok    = !div_diff[len];
    if (md_div) begin
      step_hi = div_ok ? div_diff[len-1:0] : div_shift[len-1:0];
      step_lo = {acc_lo[len-2:0], div_ok};
    end else begin
      step_hi = mul_sum[len:1];
      step_lo = {mul_sum[0], acc_lo[len-1:1]};
    end
  end

  // Multiply/divide sequencer and HI/LO ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      md_div  <= 1'b0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state   <= BUSY;
            count   <= '0;
            md_div  <= (alu_op == ALU_DIVU);
            operand <= (alu_op == ALU_DIVU) ? op_b : op_a;
            acc_hi  <= '0;
            acc_lo  <= (alu_op == ALU_DIVU) ? op_a : op_b;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CW'(1);
          if (count == LAST) begin
            hi_reg <= step_hi;
            lo_reg <= step_lo;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; flushed or stalled cycles insert a zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr_mem      <= '0;
      out_write_data    <= '0;
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      out_zero_flag     <= 1'b0;
      out_pc_branch     <= '0;
    end else if (flush || stall) begin
      out_addr_mem      <= '0;
      out_write_data    <= '0;
      out_memory_bus    <= '0;
      out_writeBack_bus <= '0;
      out_write_reg     <= '0;
      out_zero_flag     <= 1'b0;
      out_pc_branch     <= '0;
    end else begin
      out_addr_mem      <= alu_res;
      out_write_data    <= in_read_data_2;
      out_memory_bus    <= in_memory_bus;
      out_writeBack_bus <= in_writeBack_bus;
      out_write_reg     <= write_reg;
      out_zero_flag     <= (alu_res == '0);
      out_pc_branch     <= pc_branch;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: scoreboard of expected EX/MEM
// entries, independent HI/LO model, stall/flush/reset scenarios.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pc_next, in_read_data_1, in_read_data_2, in_sign_extend;
  logic [4:0]  in_shamt, in_rt, in_rd;
  logic [5:0]  in_execute_bus;
  logic [2:0]  in_memory_bus;
  logic [1:0]  in_writeBack_bus;
  logic        flush;
  logic        stall;
  logic [31:0] out_addr_mem, out_write_data, out_pc_branch;
  logic [2:0]  out_memory_bus;
  logic [1:0]  out_writeBack_bus;
  logic [4:0]  out_write_reg;
  logic        out_zero_flag;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .in_pc_next(in_pc_next), .in_read_data_1(in_read_data_1),
    .in_read_data_2(in_read_data_2), .in_sign_extend(in_sign_extend),
    .in_shamt(in_shamt), .in_rt(in_rt), .in_rd(in_rd),
    .in_execute_bus(in_execute_bus), .in_memory_bus(in_memory_bus),
    .in_writeBack_bus(in_writeBack_bus), .flush(flush), .stall(stall),
    .out_addr_mem(out_addr_mem), .out_write_data(out_write_data),
    .out_memory_bus(out_memory_bus), .out_writeBack_bus(out_writeBack_bus),
    .out_write_reg(out_write_reg), .out_zero_flag(out_zero_flag),
    .out_pc_branch(out_pc_branch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mbus;
    logic [1:0]  wbus;
    logic [4:0]  wreg;
    logic        zero;
    logic [31:0] pcb;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_addr"}, 64'(out_addr_mem), 64'd0);
    check_eq({tag, "_buses"}, 64'({out_memory_bus, out_writeBack_bus}), 64'd0);
    check_eq({tag, "_wreg"}, 64'(out_write_reg), 64'd0);
    check_eq({tag, "_pcb"}, 64'(out_pc_branch), 64'd0);
    check_eq({tag, "_wdata_zero"}, 64'({out_write_data, 31'd0, out_zero_flag}), 64'd0);
  endtask

  task automatic set_inputs(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] rt,
                            input logic [4:0] rd, input logic regdst, input logic alusrc,
                            input logic [31:0] pc, input logic [2:0] mbus, input logic [1:0] wbus);
    in_read_data_1   = a;
    in_read_data_2   = b;
    in_sign_extend   = imm;
    in_shamt         = sh;
    in_rt            = rt;
    in_rd            = rd;
    in_execute_bus   = {op, alusrc, regdst};
    in_pc_next       = pc;
    in_memory_bus    = mbus;
    in_writeBack_bus = wbus;
  endtask

  // Drive one instruction at a negedge, push its expected EX/MEM entry, follow
  // any stall, then pop and compare once the entry is captured.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh,
                           input logic [4:0] rt, input logic [4:0] rd, input logic regdst,
                           input logic alusrc, input logic [31:0] pc, input logic [2:0] mbus,
                           input logic [1:0] wbus);
    exp_t        e;
    logic [31:0] bv, res;
    logic [63:0] prod;
    logic        md;
    int          n_st;
    flush = 1'b0;
    set_inputs(op, a, b, imm, sh, rt, rd, regdst, alusrc, pc, mbus, wbus);
    bv  = alusrc ? imm : b;
    md  = (op == 4'd12) || (op == 4'd13);
    res = '0;
    case (op)
      4'd0:  res = a & bv;
      4'd1:  res = a | bv;
      4'd2:  res = a + bv;
      4'd3:  res = a ^ bv;
      4'd4:  res = ~(a | bv);
      4'd5:  res = a - bv;
      4'd6:  res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
      4'd7:  res = (a < bv) ? 32'd1 : 32'd0;
      4'd8:  res = bv << sh;
      4'd9:  res = bv >> sh;
      4'd10: res = 32'($signed(bv) >>> sh);
      4'd11: res = {bv[15:0], 16'd0};
      4'd14: res = m_hi;
      4'd15: res = m_lo;
      default: res = '0;
    endcase
    e.addr  = res;
    e.wdata = b;
    e.mbus  = mbus;
    e.wbus  = wbus;
    e.wreg  = regdst ? rd : rt;
    e.zero  = (res == 32'd0);
    e.pcb   = pc + {imm[29:0], 2'b00};
    sb_q.push_back(e);
    if (op == 4'd12) begin
      prod = {32'd0, a} * {32'd0, bv};
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end else if (op == 4'd13) begin
      if (bv == 32'd0) begin
        m_hi = a;
        m_lo = 32'hFFFF_FFFF;
      end else begin
        m_hi = a % bv;
        m_lo = a / bv;
      end
    end
    #1;
    n_st = 0;
    while (stall === 1'b1 && n_st < 100) begin
      n_st++;
      @(posedge clk); #1;
      check_eq({tag, "_bubble"}, 64'({out_memory_bus, out_writeBack_bus, out_addr_mem}), 64'd0);
    end
    check_eq({tag, "_stall_cycles"}, 64'(n_st), md ? 64'd33 : 64'd0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check_eq({tag, "_addr"}, 64'(out_addr_mem), 64'(e.addr));
    check_eq({tag, "_wdata"}, 64'(out_write_data), 64'(e.wdata));
    check_eq({tag, "_buses"}, 64'({out_memory_bus, out_writeBack_bus}), 64'({e.mbus, e.wbus}));
    check_eq({tag, "_wreg"}, 64'(out_write_reg), 64'(e.wreg));
    check_eq({tag, "_zero"}, 64'(out_zero_flag), 64'(e.zero));
    check_eq({tag, "_pcb"}, 64'(out_pc_branch), 64'(e.pcb));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rop;
    reset = 1'b1;
    flush = 1'b0;
    set_inputs(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd0);
    #2;
    check_outputs_zero("reset");
    check_eq("reset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_instr("add",  4'd2,  32'd5, 32'hFFFF_FFFD, 32'h0, 5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 32'h40, 3'b000, 2'b11);
    run_instr("sub",  4'd5,  32'd4, 32'd4, 32'h0, 5'd0, 5'd7, 5'd1, 1'b0, 1'b0, 32'h44, 3'b000, 2'b01);
    run_instr("slt",  4'd6,  32'hFFFF_FFFF, 32'd1, 32'h0, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 32'h48, 3'b000, 2'b01);
    run_instr("sltu", 4'd7,  32'hFFFF_FFFF, 32'd1, 32'h0, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 32'h4C, 3'b000, 2'b01);
    run_instr("sra",  4'd10, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd6, 5'd8, 1'b1, 1'b0, 32'h50, 3'b000, 2'b01);
    run_instr("lui",  4'd11, 32'h0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 32'h54, 3'b000, 2'b01);
    run_instr("branch", 4'd5, 32'd3, 32'd3, 32'hFFFF_FFFF, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h100, 3'b100, 2'b00);
    run_instr("nor",  4'd4,  32'h0F0F_0000, 32'h0000_00FF, 32'h0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 32'h58, 3'b010, 2'b11);
    run_instr("sll",  4'd8,  32'h0, 32'h0000_0003, 32'h0, 5'd31, 5'd1, 5'd2, 1'b1, 1'b0, 32'h5C, 3'b000, 2'b01);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 13));
      if (rop >= 4'd12) rop = rop + 4'd2;
      run_instr("rand", rop, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end

    run_instr("multu", 4'd12, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h200, 3'b000, 2'b00);
    run_instr("mfhi1", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd10, 1'b1, 1'b0, 32'h204, 3'b000, 2'b01);
    run_instr("mflo1", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd11, 1'b1, 1'b0, 32'h208, 3'b000, 2'b01);
    run_instr("divu7", 4'd13, 32'd100, 32'd7, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h20C, 3'b000, 2'b00);
    run_instr("mfhi2", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd12, 1'b1, 1'b0, 32'h210, 3'b000, 2'b01);
    run_instr("mflo2", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd13, 1'b1, 1'b0, 32'h214, 3'b000, 2'b01);
    run_instr("mult_r", 4'd12, 32'h1234_5678, 32'h9ABC_DEF1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h218, 3'b000, 2'b00);
    run_instr("mfhi3", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd12, 1'b1, 1'b0, 32'h21C, 3'b000, 2'b01);
    run_instr("mflo3", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd13, 1'b1, 1'b0, 32'h220, 3'b000, 2'b01);
    run_instr("divu0", 4'd13, 32'd100, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h224, 3'b000, 2'b00);
    run_instr("mfhi4", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd14, 1'b1, 1'b0, 32'h228, 3'b000, 2'b01);
    run_instr("mflo4", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd15, 1'b1, 1'b0, 32'h22C, 3'b000, 2'b01);

    // Flush in the middle of BUSY: stall drops at once, HI/LO keep old values.
    set_inputs(4'd12, 32'd3, 32'd5, 32'h0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h300, 3'b010, 2'b11);
    #1;
    check_eq("flush_busy_start_stall", 64'(stall), 64'd1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check_eq("flush_busy_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    #1;
    check_eq("flush_busy_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check_eq("flush_busy_bubble", 64'({out_memory_bus, out_writeBack_bus}), 64'd0);
    @(negedge clk);
    run_instr("flush_mfhi", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 32'h304, 3'b000, 2'b01);
    run_instr("flush_mflo", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 32'h308, 3'b000, 2'b01);

    // Flush beats a MULTU start in IDLE, and kills a normal instruction.
    flush = 1'b1;
    set_inputs(4'd12, 32'd7, 32'd9, 32'h0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h400, 3'b001, 2'b10);
    #1;
    check_eq("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check_eq("flush_start_bubble", 64'({out_memory_bus, out_writeBack_bus}), 64'd0);
    @(negedge clk);
    set_inputs(4'd2, 32'd7, 32'd9, 32'h0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h404, 3'b011, 2'b11);
    @(posedge clk); #1;
    check_eq("flush_add_bubble", 64'({out_memory_bus, out_writeBack_bus, out_addr_mem}), 64'd0);
    @(negedge clk);
    run_instr("after_flush_mflo", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 32'h408, 3'b000, 2'b01);

    // Asynchronous reset clears a live EX/MEM entry without a clock edge.
    run_instr("pre_reset_add", 4'd2, 32'd10, 32'd20, 32'h4, 5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 32'h500, 3'b110, 2'b11);
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    #2;
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of BUSY clears HI/LO.
    run_instr("pre_divu", 4'd13, 32'd1000, 32'd3, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h600, 3'b000, 2'b00);
    set_inputs(4'd12, 32'hFFFF_0000, 32'h0001_0001, 32'h0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h604, 3'b000, 2'b01);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outputs_zero("busy_reset");
    check_eq("busy_reset_stall", 64'(stall), 64'd1);
    m_hi = '0;
    m_lo = '0;
    set_inputs(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_instr("reset_mfhi", 4'd14, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 32'h700, 3'b000, 2'b01);
    run_instr("reset_mflo", 4'd15, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 32'h704, 3'b000, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 5-stage MIPS pipeline, between the ID/EX register and the memory stage. Selects ALU operands, computes the ALU result, zero flag and branch target, and chooses the destination register. Owns the HI/LO registers with a 32-iteration unsigned multiply/divide FSM that stalls the front end while busy. Ends in the EX/MEM pipeline register that feeds the memory stage.

## Interface
- len, 32, datapath width
- NB, $clog2(len), register-index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_pc_next  in  len  PC+4 of the instruction in EX
- in_read_data_1 / in_read_data_2  in  len  rs / rt register values
- in_sign_extend  in  len  sign-extended immediate
- in_shamt  in  5  shift amount
- in_rt / in_rd  in  NB  candidate destination indices
- in_execute_bus  in  6  [0] RegDst (1=rd), [1] ALUSrc (1=immediate), [5:2] alu_op
- in_memory_bus  in  3  [0] MemWrite, [1] MemRead, [2] Branch; passed through
- in_writeBack_bus  in  2  passed through
- flush  in  1  branch taken in memory stage; kill the instruction in EX
- stall  out  1  freeze PC, IF/ID and ID/EX (combinational)
- out_addr_mem  out  len  registered ALU result
- out_write_data  out  len  registered rt value (store data)
- out_memory_bus  out  3  registered
- out_writeBack_bus  out  2  registered
- out_write_reg  out  NB  registered destination index
- out_zero_flag  out  1  registered (ALU result == 0)
- out_pc_branch  out  len  registered in_pc_next + (in_sign_extend << 2)

## Operation
- A = in_read_data_1. B = ALUSrc ? in_sign_extend : in_read_data_2.
- alu_op codes:
  - 0 AND, 1 OR, 2 ADD (wraps, no trap), 3 XOR, 4 NOR, 5 SUB
  - 6 SLT (signed, result 0/1), 7 SLTU
  - 8 SLL B by in_shamt, 9 SRL, 10 SRA
  - 11 LUI (B << 16)
  - 12 MULTU, 13 DIVU (ALU result 0)
  - 14 MFHI, 15 MFLO
- out_write_reg = RegDst ? in_rd : in_rt.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, alu_op is 12 or 13, flush=0: latch A, B and the operation; zero the iteration counter; go to BUSY.
  - BUSY: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle. At counter = 31, write HI/LO and go to DONE.
  - DONE: go to IDLE.
- Results: MULTU gives {HI,LO} = A×B (64-bit). DIVU gives LO = A/B, HI = A%B. For B = 0: LO = 0xFFFFFFFF, HI = A.
- stall = (IDLE and alu_op ∈ {12,13} and !flush) or BUSY. stall is low in DONE, so the MULTU/DIVU advances that cycle.
- Pipeline register, every clock edge:
  - flush=1 or stall=1: load a bubble (out_memory_bus = 0, out_writeBack_bus = 0; other fields don't-care, driven to 0).
  - Otherwise: capture all computed values.
- flush while in BUSY or DONE: FSM goes to IDLE next edge, HI/LO unchanged, stall drops immediately.
- flush has priority over a simultaneous MULTU/DIVU start.

## Timing
- Reset (asynchronous):
  - all registered outputs 0
  - HI = LO = 0
  - FSM IDLE, counter 0
  - stall then follows its combinational equation
- Non-multicycle ops: result at outputs one cycle after the instruction is in EX.
- MULTU/DIVU, instruction present at cycle 0 (IDLE):
  - stall high cycles 0–32
  - HI/LO valid after the edge ending cycle 32
  - DONE in cycle 33, instruction captured as a normal entry at the end of cycle 33 (34 cycles in EX)
  - MFHI/MFLO entering EX at cycle 34 reads the new values.
- MFHI/MFLO in EX during DONE (impossible under correct stall): reads the updated HI/LO.
- No forwarding or HI/LO hazard logic inside this block beyond the stall.

## Test plan
- ADD 5 + (−3), RegDst=1, rd=9 → next cycle out_addr_mem=2, out_write_reg=9, out_zero_flag=0; SUB 4−4 → out_zero_flag=1.
- SLT A=0xFFFFFFFF, B=1 → 1; SLTU same operands → 0; SRA 0x80000000 by 4 → 0xF8000000; LUI imm 0x1234 → 0x12340000.
- Branch target: in_pc_next=0x100, in_sign_extend=0xFFFFFFFF → out_pc_branch=0xFC; in_memory_bus=3'b100 passed through.
- MULTU 0xFFFFFFFF×2:
  - stall high exactly 33 cycles, bubbles on EX/MEM during stall
  - then HI=1, LO=0xFFFFFFFE
  - following MFHI → 1, MFLO → 0xFFFFFFFE
- DIVU 100/7 → LO=14, HI=2; DIVU 100/0 → LO=0xFFFFFFFF, HI=100.
- Start MULTU, assert flush at BUSY cycle 10:
  - stall falls same cycle, FSM IDLE next edge, HI/LO keep prior values
  - mid-BUSY asynchronous reset clears HI/LO and all outputs immediately.
